// File: rtl/wb_bridge_pkg.sv
// Shared types and widths for the Wishbone timeout bridge.
// Holds FSM states, response kinds and the default timeout read pattern.
package wb_bridge_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] WB_DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    RSP_ACK = 1'b0,
    RSP_ERR = 1'b1
  } rsp_kind_e;

endpackage

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone bridge: forwards one master cycle downstream and aborts it after TIMEOUT_CYCLES strobes.
// Optional WB_TIMEOUT_LOG_EN adds last-timeout address and a saturating timeout count.
module wb_timeout_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYCLES = 16,
  parameter logic [WB_DAT_W-1:0]  TIMEOUT_DATA   = WB_DEFAULT_TIMEOUT_DATA,
  parameter bit                   ERR_ON_TIMEOUT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_wb_cyc_i,
  input  logic                m_wb_stb_i,
  input  logic                m_wb_we_i,
  input  logic [WB_SEL_W-1:0] m_wb_sel_i,
  input  logic [WB_ADR_W-1:0] m_wb_adr_i,
  input  logic [WB_DAT_W-1:0] m_wb_dat_i,
  output logic [WB_DAT_W-1:0] m_wb_dat_o,
  output logic                m_wb_ack_o,
  output logic                m_wb_err_o,
  output logic                s_wb_cyc_o,
  output logic                s_wb_stb_o,
  output logic                s_wb_we_o,
  output logic [WB_SEL_W-1:0] s_wb_sel_o,
  output logic [WB_ADR_W-1:0] s_wb_adr_o,
  output logic [WB_DAT_W-1:0] s_wb_dat_o,
  input  logic [WB_DAT_W-1:0] s_wb_dat_i,
  input  logic                s_wb_ack_i,
  input  logic                s_wb_err_i,
`ifdef WB_TIMEOUT_LOG_EN
  output logic [WB_ADR_W-1:0] to_last_adr_o,
  output logic [15:0]         to_count_o,
`endif
  output logic                timeout_irq_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s_act_q, s_act_d;
  logic                s_we_q, s_we_d;
  logic [WB_SEL_W-1:0] s_sel_q, s_sel_d;
  logic [WB_ADR_W-1:0] s_adr_q, s_adr_d;
  logic [WB_DAT_W-1:0] s_dat_q, s_dat_d;
  logic [WB_DAT_W-1:0] m_dat_q, m_dat_d;
  logic                m_ack_q, m_ack_d;
  logic                m_err_q, m_err_d;
  logic                irq_q, irq_d;
  logic                rsp_vld;
  rsp_kind_e           rsp_kind;
`ifdef WB_TIMEOUT_LOG_EN
  logic [WB_ADR_W-1:0] to_last_adr_q, to_last_adr_d;
  logic [15:0]         to_count_q, to_count_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_act_d  = s_act_q;
    s_we_d   = s_we_q;
    s_sel_d  = s_sel_q;
    s_adr_d  = s_adr_q;
    s_dat_d  = s_dat_q;
    m_dat_d  = m_dat_q;
    irq_d    = 1'b0;
    rsp_vld  = 1'b0;
    rsp_kind = RSP_ACK;
`ifdef WB_TIMEOUT_LOG_EN
    to_last_adr_d = to_last_adr_q;
    to_count_d    = to_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i) begin
          s_we_d  = m_wb_we_i;
          s_sel_d = m_wb_sel_i;
          s_adr_d = m_wb_adr_i;
          s_dat_d = m_wb_dat_i;
          s_act_d = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // Master abort outranks any slave response arriving the same cycle.
        if (!m_wb_cyc_i) begin
          s_act_d = 1'b0;
          state_d = IDLE;
        end else if (s_wb_ack_i || s_wb_err_i) begin
          m_dat_d  = s_wb_dat_i;
          s_act_d  = 1'b0;
          rsp_vld  = 1'b1;
          rsp_kind = s_wb_ack_i ? RSP_ACK : RSP_ERR;
          state_d  = RESP;
        end else if (cnt_q == CNT_TERM) begin
          m_dat_d  = TIMEOUT_DATA;
          s_act_d  = 1'b0;
          irq_d    = 1'b1;
          rsp_vld  = 1'b1;
          rsp_kind = ERR_ON_TIMEOUT ? RSP_ERR : RSP_ACK;
          state_d  = RESP;
`ifdef WB_TIMEOUT_LOG_EN
          to_last_adr_d = s_adr_q;
          if (to_count_q != 16'hFFFF) begin
            to_count_d = to_count_q + 16'd1;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_act_d = 1'b0;
      end
    endcase

    m_ack_d = rsp_vld && (rsp_kind == RSP_ACK);
    m_err_d = rsp_vld && (rsp_kind == RSP_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_act_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_sel_q <= '0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      m_dat_q <= '0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      irq_q   <= 1'b0;
`ifdef WB_TIMEOUT_LOG_EN
      to_last_adr_q <= '0;
      to_count_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_act_q <= s_act_d;
      s_we_q  <= s_we_d;
      s_sel_q <= s_sel_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      m_dat_q <= m_dat_d;
      m_ack_q <= m_ack_d;
      m_err_q <= m_err_d;
      irq_q   <= irq_d;
`ifdef WB_TIMEOUT_LOG_EN
      to_last_adr_q <= to_last_adr_d;
      to_count_q    <= to_count_d;
`endif
    end
  end

  assign s_wb_cyc_o    = s_act_q;
  assign s_wb_stb_o    = s_act_q;
  assign s_wb_we_o     = s_we_q;
  assign s_wb_sel_o    = s_sel_q;
  assign s_wb_adr_o    = s_adr_q;
  assign s_wb_dat_o    = s_dat_q;
  assign m_wb_dat_o    = m_dat_q;
  assign m_wb_ack_o    = m_ack_q;
  assign m_wb_err_o    = m_err_q;
  assign timeout_irq_o = irq_q;
`ifdef WB_TIMEOUT_LOG_EN
  assign to_last_adr_o = to_last_adr_q;
  assign to_count_o    = to_count_q;
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed bench for wb_timeout_bridge: one instance acks on timeout, a second signals err on timeout.
module tb_wb_timeout_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_wdat;
  logic [31:0] s_rdat;
  logic        s_ack, s_err;

  logic [31:0] m_rdat, s_adr, s_wdat;
  logic        m_ack, m_err, s_cyc, s_stb, s_we, irq;
  logic [3:0]  s_sel;
  logic [31:0] e_m_rdat, e_s_adr, e_s_wdat;
  logic        e_m_ack, e_m_err, e_s_cyc, e_s_stb, e_s_we, e_irq;
  logic [3:0]  e_s_sel;
`ifdef WB_TIMEOUT_LOG_EN
  logic [31:0] to_adr, e_to_adr;
  logic [15:0] to_cnt, e_to_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int nstb;

  always #5 clk = ~clk;

  wb_timeout_bridge #(.TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hDEADBEEF), .ERR_ON_TIMEOUT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we), .m_wb_sel_i(m_sel),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_wdat), .m_wb_dat_o(m_rdat),
    .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_sel_o(s_sel),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_dat_i(s_rdat),
    .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
`ifdef WB_TIMEOUT_LOG_EN
    .to_last_adr_o(to_adr), .to_count_o(to_cnt),
`endif
    .timeout_irq_o(irq)
  );

  wb_timeout_bridge #(.TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hDEADBEEF), .ERR_ON_TIMEOUT(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we), .m_wb_sel_i(m_sel),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_wdat), .m_wb_dat_o(e_m_rdat),
    .m_wb_ack_o(e_m_ack), .m_wb_err_o(e_m_err),
    .s_wb_cyc_o(e_s_cyc), .s_wb_stb_o(e_s_stb), .s_wb_we_o(e_s_we), .s_wb_sel_o(e_s_sel),
    .s_wb_adr_o(e_s_adr), .s_wb_dat_o(e_s_wdat), .s_wb_dat_i(s_rdat),
    .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
`ifdef WB_TIMEOUT_LOG_EN
    .to_last_adr_o(e_to_adr), .to_count_o(e_to_cnt),
`endif
    .timeout_irq_o(e_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and counts downstream strobe cycles; slave answers in strobe cycle rsp_at (0 = never).
  // Returns with the bridge in its response cycle; bounded at 40 strobe cycles.
  task automatic run_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int rsp_at, input logic use_err,
                         input logic [31:0] rdat, output int n_out);
    int n;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_wdat = dat; m_sel = sel;
    tick();
    n = 0;
    while (s_stb === 1'b1 && n < 40) begin
      n++;
      if (n == rsp_at) begin
        s_ack = !use_err; s_err = use_err; s_rdat = rdat;
      end
      tick();
      s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
    end
    n_out = n;
  endtask

  task automatic end_txn();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; m_cyc = 0; m_stb = 0; m_we = 0; m_sel = 0; m_adr = 0; m_wdat = 0;
    s_rdat = 0; s_ack = 0; s_err = 0;
    tick(); tick();
    chk("rst_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("rst_s_stb", {31'b0, s_stb}, 32'd0);
    chk("rst_m_ack", {31'b0, m_ack}, 32'd0);
    chk("rst_m_err", {31'b0, m_err}, 32'd0);
    chk("rst_m_dat", m_rdat, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write, slave acks on first strobe cycle
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h3000_0004; m_wdat = 32'h1234_5678; m_sel = 4'hF;
    tick();
    chk("wr_s_stb", {31'b0, s_stb}, 32'd1);
    chk("wr_s_cyc", {31'b0, s_cyc}, 32'd1);
    chk("wr_s_adr", s_adr, 32'h3000_0004);
    chk("wr_s_dat", s_wdat, 32'h1234_5678);
    chk("wr_s_sel", {28'b0, s_sel}, 32'hF);
    chk("wr_s_we", {31'b0, s_we}, 32'd1);
    chk("wr_ack_early", {31'b0, m_ack}, 32'd0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    chk("wr_ack", {31'b0, m_ack}, 32'd1);
    chk("wr_s_stb_drop", {31'b0, s_stb}, 32'd0);
    chk("wr_irq", {31'b0, irq}, 32'd0);
    end_txn();
    chk("wr_ack_1cyc", {31'b0, m_ack}, 32'd0);

    // Read, slave answers on 5th strobe cycle
    run_req(1'b0, 32'h3000_0010, 32'h0, 4'hF, 5, 1'b0, 32'hCAFE_0001, nstb);
    chk("rd5_nstb", nstb, 32'd5);
    chk("rd5_ack", {31'b0, m_ack}, 32'd1);
    chk("rd5_err", {31'b0, m_err}, 32'd0);
    chk("rd5_dat", m_rdat, 32'hCAFE_0001);
    end_txn();
    chk("rd5_ack_1cyc", {31'b0, m_ack}, 32'd0);
    chk("rd5_dat_hold", m_rdat, 32'hCAFE_0001);

    // Silent slave: both timeout flavours
    run_req(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 1'b0, 32'h0, nstb);
    chk("to_nstb", nstb, 32'd16);
    chk("to_ack", {31'b0, m_ack}, 32'd1);
    chk("to_err", {31'b0, m_err}, 32'd0);
    chk("to_dat", m_rdat, 32'hDEADBEEF);
    chk("to_irq", {31'b0, irq}, 32'd1);
    chk("toe_err", {31'b0, e_m_err}, 32'd1);
    chk("toe_ack", {31'b0, e_m_ack}, 32'd0);
    chk("toe_dat", e_m_rdat, 32'hDEADBEEF);
    chk("toe_irq", {31'b0, e_irq}, 32'd1);
    end_txn();
    chk("to_irq_1cyc", {31'b0, irq}, 32'd0);
    chk("toe_err_1cyc", {31'b0, e_m_err}, 32'd0);

    // Slave ack on the terminal (16th) strobe cycle wins over timeout
    run_req(1'b0, 32'h3000_0030, 32'h0, 4'hF, 16, 1'b0, 32'h55AA_1234, nstb);
    chk("t16_nstb", nstb, 32'd16);
    chk("t16_ack", {31'b0, m_ack}, 32'd1);
    chk("t16_dat", m_rdat, 32'h55AA_1234);
    chk("t16_irq", {31'b0, irq}, 32'd0);
    chk("t16e_err", {31'b0, e_m_err}, 32'd0);
    end_txn();

    // Slave error response
    run_req(1'b0, 32'h3000_0040, 32'h0, 4'h3, 3, 1'b1, 32'h0BAD_0BAD, nstb);
    chk("serr_err", {31'b0, m_err}, 32'd1);
    chk("serr_ack", {31'b0, m_ack}, 32'd0);
    chk("serr_dat", m_rdat, 32'h0BAD_0BAD);
    end_txn();

    // Master abort in strobe cycle 3
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h3000_0050; m_sel = 4'hF;
    tick(); tick(); tick();
    chk("ab_s_stb_c3", {31'b0, s_stb}, 32'd1);
    m_cyc = 1'b0; m_stb = 1'b0;
    tick();
    chk("ab_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("ab_s_stb", {31'b0, s_stb}, 32'd0);
    chk("ab_ack", {31'b0, m_ack}, 32'd0);
    chk("ab_err", {31'b0, m_err}, 32'd0);
    tick();
    chk("ab_ack_later", {31'b0, m_ack}, 32'd0);
    chk("ab_s_cyc_later", {31'b0, s_cyc}, 32'd0);
    run_req(1'b0, 32'h3000_0060, 32'h0, 4'hF, 1, 1'b0, 32'h0000_0777, nstb);
    chk("ab_next_nstb", nstb, 32'd1);
    chk("ab_next_ack", {31'b0, m_ack}, 32'd1);
    chk("ab_next_dat", m_rdat, 32'h0000_0777);
    end_txn();

    // Reset while a request is outstanding
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h3000_0070; m_wdat = 32'hA5A5_A5A5; m_sel = 4'hC;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mr_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("mr_s_stb", {31'b0, s_stb}, 32'd0);
    chk("mr_s_adr", s_adr, 32'd0);
    chk("mr_s_dat", s_wdat, 32'd0);
    chk("mr_m_dat", m_rdat, 32'd0);
    chk("mr_ack", {31'b0, m_ack}, 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_idle_s_stb", {31'b0, s_stb}, 32'd0);

`ifdef WB_TIMEOUT_LOG_EN
    chk("log_rst_cnt", {16'b0, to_cnt}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      run_req(1'b0, 32'h3000_0000 + (i << 16), 32'h0, 4'hF, 0, 1'b0, 32'h0, nstb);
      chk("log_nstb", nstb, 32'd16);
      end_txn();
    end
    chk("log_cnt", {16'b0, to_cnt}, 32'd3);
    chk("log_adr", to_adr, 32'h3003_0000);
    chk("loge_cnt", {16'b0, e_to_cnt}, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
